// File: rtl/mmr_fifo.sv
// Memory-mapped transmit FIFO: bus writes push entries, a valid/ready consumer drains them.
// A status/control register exposes the fill level and flags, and accepts flush/clear commands.
module mmr_fifo #(
   parameter int unsigned ABITS      = 32,
   parameter int unsigned PBITS      = 32,
   parameter int unsigned DBITS      = 8,
   parameter int unsigned DEPTH_LOG2 = 3,
   parameter logic [ABITS-1:0] ADDR  = '0,
   parameter logic [ABITS-1:0] SADDR = ADDR + ABITS'(1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             strobe,
   input  logic             rw,
   input  logic [ABITS-1:0] addr,
   input  logic [PBITS-1:0] d_in,
   output logic [PBITS-1:0] d_out,
   output logic [DBITS-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);

   logic [DBITS-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic [PBITS-1:0]      d_out_q, d_out_d;

   logic             push, pop, full, push_ok, ctrl_wr, flush;
   logic [PBITS-1:0] status;

   assign out_valid = (count_q != '0);
   assign out_data  = mem[rd_ptr_q];
   assign d_out     = d_out_q;

   assign full    = (count_q == FULL_CNT);
   assign push    = strobe & rw & (addr == ADDR);
   assign pop     = out_valid & out_ready;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign push_ok = push & (~full | pop);
   assign ctrl_wr = strobe & rw & (addr == SADDR);
   assign flush   = ctrl_wr & d_in[0];

   always_comb begin
      status                 = '0;
      status[DEPTH_LOG2:0]   = count_q;
      status[16]             = ~out_valid;
      status[17]             = full;
      status[18]             = overflow_q;
   end

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      d_out_d    = d_out_q;

      // Flush wins over a concurrent pop; that beat is lost to the consumer.
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (push_ok && !pop)      count_d = count_q + CNT_ONE;
         else if (!push_ok && pop) count_d = count_q - CNT_ONE;
      end

      if (push && !push_ok)          overflow_d = 1'b1;
      else if (ctrl_wr && d_in[1])   overflow_d = 1'b0;

      if (strobe && !rw) begin
         if (addr == SADDR)     d_out_d = status;
         else if (addr == ADDR) d_out_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         d_out_q    <= '0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         d_out_q    <= d_out_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= d_in[DBITS-1:0];
   end

endmodule

// File: doc/mmr_fifo.md
# mmr_fifo

Memory-mapped transmit FIFO that sits downstream of the CPU data bus, alongside the plain memory-mapped registers. It uses the same strobe/rw/addr/d_in/d_out bus protocol. Bus writes to its data address push words into a small circular buffer. A downstream consumer drains the buffer through a valid/ready handshake. A status address exposes fill level, full/empty and a sticky overflow flag, and accepts flush and clear commands.

## Interface
- ADDR, 0: bus address of the data (push) register
- SADDR, ADDR+1: bus address of the status/control register
- ABITS, 32: bus address width
- PBITS, 32: bus data width
- DBITS, 8: FIFO entry width; DBITS <= PBITS
- DEPTH_LOG2, 3: log2 of entry count (DEPTH = 8); must be < 16
- clk  in  1  single clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- strobe  in  1  bus cycle valid
- rw  in  1  1 = write, 0 = read
- addr  in  ABITS  bus address
- d_in  in  PBITS  bus write data
- d_out  out  PBITS  registered bus read data
- out_data  out  DBITS  head entry (first-word-fall-through)
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head this cycle

## Operation
- Storage: DEPTH x DBITS array; rd_ptr and wr_ptr are DEPTH_LOG2 bits and wrap modulo DEPTH; count is DEPTH_LOG2+1 bits, range 0..DEPTH.
- push = strobe & rw & addr==ADDR. Data stored is d_in[DBITS-1:0].
- pop = out_valid & out_ready.
- Push is accepted when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
- A push that is not accepted is dropped. The FIFO is unchanged and overflow is set (sticky).
- Simultaneous accepted push and pop: both pointers advance and count is unchanged.
- Status word, all other bits 0: [DEPTH_LOG2:0] count; bit 16 empty; bit 17 full; bit 18 overflow.
- Read of SADDR: d_out <= status word, sampled from pre-edge state.
- Read of ADDR: d_out <= 0. The data register is write-only; the read does not pop.
- Read of any other address, or no strobe: d_out holds its value.
- Write of SADDR:
  - d_in[0]=1 flushes: pointers and count go to 0.
  - d_in[1]=1 clears overflow.
  - Both bits may be set together.
- Flush has priority over a concurrent pop. The pop is discarded and the consumer must treat that beat as lost.
- Flush does not clear overflow unless d_in[1] is also set.
- out_valid = (count != 0). out_data = mem[rd_ptr], combinational from registered state.
- out_data is don't-care when out_valid = 0; the bench must not check it then.

## Timing
- Reset (asynchronous assert):
  - d_out = 0; count = 0; rd_ptr = wr_ptr = 0; overflow = 0.
  - out_valid = 0.
  - Array contents are not reset.
- Deassertion of reset_n is synchronised by the system. The block is operational on the first rising edge after deassertion.
- Push at edge N: out_valid is high and out_data is valid after edge N, i.e. one-cycle latency from bus write to consumer visibility.
- Pop at edge N: the next entry appears after edge N. out_valid falls after edge N if count was 1.
- Status read at edge N returns the state before edge N. A push at edge N-1 is visible in a read at edge N.
- out_valid must not depend combinationally on out_ready.
- The consumer may hold out_ready high continuously; this gives one pop per cycle.
- Reset mid-operation discards all entries immediately, regardless of pending out_ready.

## Test plan
- Reset: hold reset_n=0 with random bus traffic.
  - Required: d_out=0, out_valid=0.
  - After release, a status read returns 0x00010000 (empty, count 0).
- Push and drain: write 0x11, 0x22, 0x33 to ADDR with out_ready=0, then read SADDR.
  - Required: read returns 0x00000003.
  - Raise out_ready; out_data must be 0x11, 0x22, 0x33 on consecutive cycles, then out_valid=0.
- Overflow: out_ready=0, push 0x00..0x08 (9 writes).
  - Required: status reads 0x00060008 (full, overflow, count 8).
  - Draining yields 0x00..0x07; 0x08 is lost.
  - Writing 0x2 to SADDR then clears bit 18.
- Full plus concurrent push/pop: fill to 8, then hold out_ready=1 while pushing 0xAA.
  - Required: count stays 8, overflow stays 0.
  - 0xAA emerges after the original 8 entries.
  - Pointer wrap past index 7 is exercised.
- Flush vs pop: 4 entries, out_ready=1, write 0x1 to SADDR.
  - Required: after the edge, out_valid=0 and status reads 0x00010000.
  - The next push of 0x55 appears as out_data=0x55.
- Reset mid-drain: 5 entries, out_ready=1; assert reset_n low asynchronously between edges.
  - Required: out_valid drops without waiting for an edge.
  - After release, count is 0 and a push of 0x77 is delivered first.
